// File: rtl/keychain_pkg.sv
// Shared types for the key-engine sequencer: FSM state encoding and byte width.
package keychain_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        FILL,
        CHECK,
        LAUNCH,
        WAIT,
        DRAIN
    } seq_state_t;

endpackage

// File: rtl/rsa_block_sequencer.sv
// Byte-stream front end for exponent_modulus: packs bytes into words, screens them
// against the modulus, launches the engine and streams the result back out MSB first.
module rsa_block_sequencer
    import keychain_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] modulus_in,
    input  logic [WIDTH-1:0] exponent_in,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid_in,
    output logic             byte_ready_out,
    output logic [7:0]       byte_out,
    output logic             byte_valid_out,
    input  logic             byte_ready_in,
    output logic             eng_ready_out,
    output logic [WIDTH-1:0] eng_value_out,
    input  logic             eng_valid_in,
    input  logic [WIDTH-1:0] eng_result_in,
    output logic             err_out,
    output logic             busy_out,
    output logic [15:0]      words_done_out
);

    localparam int BYTES = WIDTH / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] eng_val_q, eng_val_d;
    logic [15:0]      done_q, done_d;

    // The exponent is consumed directly by the engine; it only passes by this block.
    logic unused_exponent;
    assign unused_exponent = ^exponent_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            word_q    <= '0;
            res_q     <= '0;
            eng_val_q <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            res_q     <= res_d;
            eng_val_q <= eng_val_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        word_d         = word_q;
        res_d          = res_q;
        eng_val_d      = eng_val_q;
        done_d         = done_q;
        byte_ready_out = 1'b0;
        byte_valid_out = 1'b0;
        eng_ready_out  = 1'b0;
        err_out        = 1'b0;

        case (state_q)
            FILL: begin
                byte_ready_out = 1'b1;
                if (byte_valid_in) begin
                    // Big-endian: earlier bytes migrate towards the MSB.
                    word_d = (word_q << BYTE_W) | WIDTH'(byte_in);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (word_q >= modulus_in) begin
                    err_out = 1'b1;
                    state_d = FILL;
                end else begin
                    eng_val_d = word_q;
                    state_d   = LAUNCH;
                end
                word_d = '0;
            end
            LAUNCH: begin
                eng_ready_out = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (eng_valid_in) begin
                    res_d   = eng_result_in;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                byte_valid_out = 1'b1;
                if (byte_ready_in) begin
                    res_d = res_q << BYTE_W;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        done_d  = done_q + 16'd1;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign byte_out       = res_q[WIDTH-1 -: BYTE_W];
    assign eng_value_out  = eng_val_q;
    assign busy_out       = (state_q != FILL);
    assign words_done_out = done_q;

endmodule

// File: tb/tb_rsa_block_sequencer.sv
// Bench for rsa_block_sequencer with a behavioural modular-exponentiation engine model.
module tb_rsa_block_sequencer;

    localparam int WIDTH   = 16;
    localparam int ENG_LAT = 6;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [WIDTH-1:0] modulus_in;
    logic [WIDTH-1:0] exponent_in;
    logic [7:0]       byte_in;
    logic             byte_valid_in;
    logic             byte_ready_out;
    logic [7:0]       byte_out;
    logic             byte_valid_out;
    logic             byte_ready_in;
    logic             eng_ready_out;
    logic [WIDTH-1:0] eng_value_out;
    logic             eng_valid_in;
    logic [WIDTH-1:0] eng_result_in;
    logic             err_out;
    logic             busy_out;
    logic [15:0]      words_done_out;

    always #5 clk_in = ~clk_in;

    rsa_block_sequencer #(.WIDTH(WIDTH)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .modulus_in     (modulus_in),
        .exponent_in    (exponent_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .byte_out       (byte_out),
        .byte_valid_out (byte_valid_out),
        .byte_ready_in  (byte_ready_in),
        .eng_ready_out  (eng_ready_out),
        .eng_value_out  (eng_value_out),
        .eng_valid_in   (eng_valid_in),
        .eng_result_in  (eng_result_in),
        .err_out        (err_out),
        .busy_out       (busy_out),
        .words_done_out (words_done_out)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0]       exp_bytes[$];
    logic [WIDTH-1:0] exp_launch[$];
    int exp_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Engine model: square-and-multiply, result after ENG_LAT cycles.
    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] e,
                                                input logic [WIDTH-1:0] m);
        longint unsigned r, x, mm;
        if (m == 0) return '0;
        mm = longint'(m);
        r  = 1 % mm;
        x  = longint'(b) % mm;
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return WIDTH'(r);
    endfunction

    logic             eng_busy;
    int               eng_cnt;
    logic             eng_valid_q;
    logic [WIDTH-1:0] eng_res_q;
    logic             stray_valid = 1'b0;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            eng_busy    <= 1'b0;
            eng_cnt     <= 0;
            eng_valid_q <= 1'b0;
            eng_res_q   <= '0;
        end else begin
            eng_valid_q <= 1'b0;
            if (eng_ready_out) begin
                eng_busy  <= 1'b1;
                eng_cnt   <= ENG_LAT;
                eng_res_q <= modexp(eng_value_out, exponent_in, modulus_in);
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    eng_valid_q <= 1'b1;
                    eng_busy    <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    assign eng_valid_in  = eng_valid_q | stray_valid;
    assign eng_result_in = stray_valid ? 16'h0BAD : eng_res_q;

    // Scoreboard monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (byte_valid_out && byte_ready_in) begin
                if (exp_bytes.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", byte_out);
                end else begin
                    check("out_byte", 32'(byte_out), 32'(exp_bytes.pop_front()));
                end
            end
            if (err_out) begin
                if (exp_err == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_err: got err_out=1, expected 0");
                end else begin
                    n_vec++;
                    exp_err--;
                end
            end
            if (eng_ready_out) begin
                if (exp_launch.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_launch: got value 0x%0h, expected no launch", eng_value_out);
                end else begin
                    check("eng_value", 32'(eng_value_out), 32'(exp_launch.pop_front()));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_in       = b;
        byte_valid_in = 1'b1;
        n = 0;
        @(negedge clk_in);
        while (!byte_ready_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (!byte_ready_out) check("byte_ready_timeout", 32'(byte_ready_out), 32'd1);
        @(posedge clk_in);
        #1;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
    endtask

    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic expect_err);
        send_byte(b0);
        send_byte(b1);
        @(negedge clk_in);
        check("err_at_t1", 32'(err_out), 32'(expect_err));
        check("no_launch_at_t1", 32'(eng_ready_out), 32'd0);
        @(negedge clk_in);
        check("launch_at_t2", 32'(eng_ready_out), 32'(!expect_err));
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_bytes.size() != 0 || busy_out) && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 300) check("idle_timeout", 32'(busy_out), 32'd0);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_in        = 1'b1;
        modulus_in    = 16'd3233;
        exponent_in   = 16'd17;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        byte_ready_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_byte_ready", 32'(byte_ready_out), 32'd1);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_byte_valid", 32'(byte_valid_out), 32'd0);
        check("rst_eng_ready", 32'(eng_ready_out), 32'd0);
        check("rst_eng_value", 32'(eng_value_out), 32'd0);
        check("rst_words_done", 32'(words_done_out), 32'd0);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;

        // 1: 65^17 mod 3233 = 2790
        exp_launch.push_back(16'h0041);
        exp_bytes.push_back(8'h0A); exp_bytes.push_back(8'hE6);
        send_word(8'h00, 8'h41, 1'b0);
        wait_idle();
        check("words_done_t1", 32'(words_done_out), 32'd1);

        // Stray engine valid while idle must not start a drain.
        stray_valid = 1'b1;
        @(posedge clk_in);
        #1 stray_valid = 1'b0;
        @(negedge clk_in);
        check("stray_busy", 32'(busy_out), 32'd0);
        check("stray_valid_out", 32'(byte_valid_out), 32'd0);
        @(posedge clk_in);
        #1;

        // 2: 2790^2753 mod 3233 = 65; bytes offered while busy are refused.
        exponent_in = 16'd2753;
        exp_launch.push_back(16'h0AE6);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h41);
        send_word(8'h0A, 8'hE6, 1'b0);
        byte_in = 8'h77; byte_valid_in = 1'b1;
        @(negedge clk_in);
        check("busy_ready_low", 32'(byte_ready_out), 32'd0);
        @(posedge clk_in);
        #1 byte_valid_in = 1'b0; byte_in = 8'h00;
        wait_idle();
        check("words_done_t2", 32'(words_done_out), 32'd2);

        // 3: word equal to modulus is rejected.
        exp_err++;
        send_word(8'h0C, 8'hA1, 1'b1);
        wait_idle();
        check("words_done_t3", 32'(words_done_out), 32'd2);
        check("t3_busy", 32'(busy_out), 32'd0);

        // 4: exponent 0 gives 1.
        modulus_in  = 16'd65521;
        exponent_in = 16'd0;
        exp_launch.push_back(16'h1234);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
        send_word(8'h12, 8'h34, 1'b0);
        wait_idle();
        check("words_done_t4", 32'(words_done_out), 32'd3);

        // 5: test 1 with a 5-cycle sink stall between the two result bytes.
        modulus_in    = 16'd3233;
        exponent_in   = 16'd17;
        byte_ready_in = 1'b0;
        exp_launch.push_back(16'h0041);
        exp_bytes.push_back(8'h0A); exp_bytes.push_back(8'hE6);
        send_word(8'h00, 8'h41, 1'b0);
        n = 0;
        @(negedge clk_in);
        while (!byte_valid_out && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("t5_first_byte", 32'(byte_out), 32'h0A);
        @(posedge clk_in);
        #1 byte_ready_in = 1'b1;
        @(posedge clk_in);
        #1 byte_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("stall_byte_out", 32'(byte_out), 32'hE6);
            check("stall_valid", 32'(byte_valid_out), 32'd1);
        end
        @(posedge clk_in);
        #1 byte_ready_in = 1'b1;
        wait_idle();
        check("words_done_t5", 32'(words_done_out), 32'd4);

        // Modulus 0: every word fails.
        modulus_in = 16'd0;
        exp_err++;
        send_word(8'h00, 8'h00, 1'b1);
        exp_err++;
        send_word(8'h12, 8'h34, 1'b1);
        wait_idle();
        check("words_done_mod0", 32'(words_done_out), 32'd4);

        // 6: reset while waiting on the engine.
        modulus_in = 16'd3233;
        exp_launch.push_back(16'h0041);
        send_word(8'h00, 8'h41, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        check("t6_busy_before_rst", 32'(busy_out), 32'd1);
        #2 rst_in = 1'b1;
        #1;
        check("t6_busy", 32'(busy_out), 32'd0);
        check("t6_byte_ready", 32'(byte_ready_out), 32'd1);
        check("t6_byte_valid", 32'(byte_valid_out), 32'd0);
        check("t6_eng_value", 32'(eng_value_out), 32'd0);
        check("t6_words_done", 32'(words_done_out), 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        exp_launch.push_back(16'h0041);
        exp_bytes.push_back(8'h0A); exp_bytes.push_back(8'hE6);
        send_word(8'h00, 8'h41, 1'b0);
        wait_idle();
        check("words_done_t6", 32'(words_done_out), 32'd1);

        repeat (3) @(posedge clk_in);
        check("left_bytes", 32'(exp_bytes.size()), 32'd0);
        check("left_launch", 32'(exp_launch.size()), 32'd0);
        check("left_err", 32'(exp_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
